// File: rtl/clk_monitor.sv
// clk_monitor: measures period and high time of a slow monitored clock in inp_clk cycles,
// reporting lock when consecutive periods agree and stall when the clock stops toggling.
module clk_monitor #(
    parameter int CNT_W      = 16,
    parameter int TIMEOUT    = 1024,
    parameter int LOCK_COUNT = 4
) (
    input  logic             inp_clk,
    input  logic             rst_n,
    input  logic             mon_clk,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             edge_rise,
    output logic             locked,
    output logic             stalled
);
    localparam int               MW      = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TOUT    = CNT_W'(TIMEOUT);
    localparam logic [MW-1:0]    LOCK_N  = MW'(LOCK_COUNT);

    typedef enum logic [1:0] {IDLE, MEASURE, LOCKED, STALLED} state_t;

    state_t           state;
    logic             s1, s2, s3;
    logic [CNT_W-1:0] cnt, hcnt;
    logic [MW-1:0]    match, match_nxt;
    logic             rise, fall, timeout, same_p;

    always_ff @(posedge inp_clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= mon_clk;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise    = s2 & ~s3;
    assign fall    = ~s2 & s3;
    // A rise landing on the timeout cycle is a valid (long) period, not a stall.
    assign timeout = (cnt == TOUT) && !rise;
    assign same_p  = (cnt == period);

    always_comb begin
        match_nxt = MW'(1);
        if (match != '0 && same_p)
            match_nxt = (match == LOCK_N) ? LOCK_N : match + MW'(1);
    end

    always_ff @(posedge inp_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            hcnt <= '0;
        end else begin
            if (rise)
                cnt <= CNT_W'(1);
            else if (cnt != CNT_MAX)
                cnt <= cnt + CNT_W'(1);

            if (rise)
                hcnt <= CNT_W'(1);
            else if (s2 && hcnt != CNT_MAX)
                hcnt <= hcnt + CNT_W'(1);
        end
    end

    always_ff @(posedge inp_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            edge_rise  <= 1'b0;
            locked     <= 1'b0;
            stalled    <= 1'b0;
            match      <= '0;
        end else begin
            edge_rise  <= rise;
            meas_valid <= 1'b0;
            if (fall && (state == MEASURE || state == LOCKED))
                high_time <= hcnt;

            case (state)
                IDLE: begin
                    if (rise) begin
                        state <= MEASURE;
                        match <= '0;
                    end else if (timeout) begin
                        state   <= STALLED;
                        stalled <= 1'b1;
                        locked  <= 1'b0;
                        match   <= '0;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period     <= cnt;
                        meas_valid <= 1'b1;
                        match      <= match_nxt;
                        if (match_nxt == LOCK_N) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end
                    end else if (timeout) begin
                        state   <= STALLED;
                        stalled <= 1'b1;
                        locked  <= 1'b0;
                        match   <= '0;
                    end
                end
                LOCKED: begin
                    if (rise) begin
                        period     <= cnt;
                        meas_valid <= 1'b1;
                        if (!same_p) begin
                            state  <= MEASURE;
                            locked <= 1'b0;
                            match  <= MW'(1);
                        end
                    end else if (timeout) begin
                        state   <= STALLED;
                        stalled <= 1'b1;
                        locked  <= 1'b0;
                        match   <= '0;
                    end
                end
                STALLED: begin
                    // First edge after a stall only re-arms; there is no valid period yet.
                    if (rise) begin
                        state   <= MEASURE;
                        stalled <= 1'b0;
                        match   <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
